// File: rtl/ipv4_fib_table_ctrl.sv
// ipv4_fib_table_ctrl: bus-mapped staging registers and a small request/ack
// sequencer for one IPv4 FIB table row (OIF, next hop, mask, network).
//
// state | meaning
// IDLE  | no table operation in flight; staging registers writable
// REQ   | issue a single-cycle table read or write request at INDEX
// WAIT  | waiting for the matching table ack, or for the timeout
module ipv4_fib_table_ctrl #(
  parameter int IPV4_FIB_LUT_ROW_BITS = 5,
  parameter int TIMEOUT_CYCLES        = 16
) (
  input  logic                             Bus2IP_Clk,
  input  logic                             reset,
  input  logic                             Bus2IP_CS,
  input  logic                             Bus2IP_RNW,
  input  logic [2:0]                       Bus2IP_Addr,
  input  logic [31:0]                      Bus2IP_Data,
  output logic [31:0]                      IP2Bus_Data,
  output logic                             IP2Bus_RdAck,
  output logic                             IP2Bus_WrAck,
  output logic                             IP2Bus_Error,
  output logic                             o_tbl_rd_req,
  output logic                             o_tbl_wr_req,
  input  logic                             i_tbl_rd_ack,
  input  logic                             i_tbl_wr_ack,
  output logic [IPV4_FIB_LUT_ROW_BITS-1:0] o_tbl_rd_addr,
  output logic [IPV4_FIB_LUT_ROW_BITS-1:0] o_tbl_wr_addr,
  input  logic [7:0]                       i_tbl_rd_oif,
  input  logic [31:0]                      i_tbl_rd_nh,
  input  logic [31:0]                      i_tbl_rd_mask,
  input  logic [31:0]                      i_tbl_rd_net,
  output logic [31:0]                      o_tbl_wr_oif,
  output logic [31:0]                      o_tbl_wr_nh,
  output logic [31:0]                      o_tbl_wr_mask,
  output logic [31:0]                      o_tbl_wr_net
);

  localparam int RB     = IPV4_FIB_LUT_ROW_BITS;
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t            state_q, state_d;
  logic              op_rd_q;
  logic [7:0]        oif_q;
  logic [31:0]       nh_q, mask_q, net_q;
  logic [RB-1:0]     index_q;
  logic              busy_q, done_q, tmo_q;
  logic [15:0]       tcnt_q;
  logic [WAIT_W-1:0] wait_cnt_q;

  // Access captured when CS is sampled; its write takes effect at the end
  // of the ack cycle so the command starts exactly in that cycle.
  logic [2:0]        acc_addr_q;
  logic [31:0]       acc_data_q;
  logic              acc_commit_q;

  logic              acc_start;
  logic              wr_err;
  logic [31:0]       rd_mux;
  logic              cmd_go;
  logic              ack_match;
  logic              done_evt;
  logic              tmo_evt;

  // CS is ignored while an ack is on the bus so every access acks once.
  assign acc_start = Bus2IP_CS && !IP2Bus_RdAck && !IP2Bus_WrAck;
  assign cmd_go    = acc_commit_q && (acc_addr_q == 3'd5);
  assign ack_match = op_rd_q ? i_tbl_rd_ack : i_tbl_wr_ack;

  assign o_tbl_rd_addr = index_q;
  assign o_tbl_wr_addr = index_q;
  assign o_tbl_wr_oif  = {24'b0, oif_q};
  assign o_tbl_wr_nh   = nh_q;
  assign o_tbl_wr_mask = mask_q;
  assign o_tbl_wr_net  = net_q;

  // Write error decode for the access being sampled now.
  always_comb begin
    wr_err = 1'b0;
    case (Bus2IP_Addr)
      3'd5:    wr_err = busy_q || (Bus2IP_Data[1:0] == 2'b00) || (Bus2IP_Data[1:0] == 2'b11);
      3'd6,
      3'd7:    wr_err = 1'b1;
      default: wr_err = busy_q;
    endcase
  end

  // Read data mux over the register map.
  always_comb begin
    rd_mux = 32'b0;
    case (Bus2IP_Addr)
      3'd0:    rd_mux = {24'b0, oif_q};
      3'd1:    rd_mux = nh_q;
      3'd2:    rd_mux = mask_q;
      3'd3:    rd_mux = net_q;
      3'd4:    rd_mux = {{(32-RB){1'b0}}, index_q};
      3'd6:    rd_mux = {29'b0, tmo_q, done_q, busy_q};
      3'd7:    rd_mux = {16'b0, tcnt_q};
      default: rd_mux = 32'b0;
    endcase
  end

  // Bus handshake: one-cycle ack/error pulse and capture of the access.
  always_ff @(posedge Bus2IP_Clk) begin
    if (reset) begin
      IP2Bus_RdAck <= 1'b0;
      IP2Bus_WrAck <= 1'b0;
      IP2Bus_Error <= 1'b0;
      IP2Bus_Data  <= 32'b0;
      acc_commit_q <= 1'b0;
      acc_addr_q   <= 3'b0;
      acc_data_q   <= 32'b0;
    end else begin
      IP2Bus_RdAck <= acc_start && Bus2IP_RNW;
      IP2Bus_WrAck <= acc_start && !Bus2IP_RNW;
      IP2Bus_Error <= acc_start && !Bus2IP_RNW && wr_err;
      IP2Bus_Data  <= (acc_start && Bus2IP_RNW) ? rd_mux : 32'b0;
      acc_commit_q <= acc_start && !Bus2IP_RNW && !wr_err;
      acc_addr_q   <= Bus2IP_Addr;
      acc_data_q   <= Bus2IP_Data;
    end
  end

  // FSM state register.
  always_ff @(posedge Bus2IP_Clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state, request pulses and completion events.
  always_comb begin
    state_d      = state_q;
    o_tbl_rd_req = 1'b0;
    o_tbl_wr_req = 1'b0;
    done_evt     = 1'b0;
    tmo_evt      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_go) state_d = ST_REQ;
      end
      ST_REQ: begin
        o_tbl_rd_req = op_rd_q;
        o_tbl_wr_req = !op_rd_q;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (ack_match) begin
          done_evt = 1'b1;
          state_d  = ST_IDLE;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_evt = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Staging registers, status, wait counter and read-data capture.
  always_ff @(posedge Bus2IP_Clk) begin
    if (reset) begin
      op_rd_q    <= 1'b0;
      oif_q      <= 8'b0;
      nh_q       <= 32'b0;
      mask_q     <= 32'b0;
      net_q      <= 32'b0;
      index_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      tcnt_q     <= 16'b0;
      wait_cnt_q <= '0;
    end else begin
      if (state_q == ST_IDLE && cmd_go) begin
        op_rd_q <= acc_data_q[1];
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        tmo_q   <= 1'b0;
      end
      if (acc_commit_q) begin
        case (acc_addr_q)
          3'd0:    oif_q   <= acc_data_q[7:0];
          3'd1:    nh_q    <= acc_data_q;
          3'd2:    mask_q  <= acc_data_q;
          3'd3:    net_q   <= acc_data_q;
          3'd4:    index_q <= acc_data_q[RB-1:0];
          default: ;
        endcase
      end
      if (state_q == ST_REQ)
        wait_cnt_q <= '0;
      else if (state_q == ST_WAIT && !ack_match)
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      if (done_evt) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
        if (op_rd_q) begin
          oif_q  <= i_tbl_rd_oif;
          nh_q   <= i_tbl_rd_nh;
          mask_q <= i_tbl_rd_mask;
          net_q  <= i_tbl_rd_net;
        end
      end
      if (tmo_evt) begin
        busy_q <= 1'b0;
        tmo_q  <= 1'b1;
        if (tcnt_q != 16'hFFFF) tcnt_q <= tcnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ipv4_fib_table_ctrl.sv
// tb_ipv4_fib_table_ctrl: directed and randomized bus/table traffic checked
// against a register-level reference model of the FIB table controller.
module tb_ipv4_fib_table_ctrl;
  localparam int RB = 5;
  localparam int TC = 16;

  logic          Bus2IP_Clk = 1'b0;
  logic          reset = 1'b1;
  logic          Bus2IP_CS = 1'b0, Bus2IP_RNW = 1'b0;
  logic [2:0]    Bus2IP_Addr = '0;
  logic [31:0]   Bus2IP_Data = '0;
  logic [31:0]   IP2Bus_Data;
  logic          IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error;
  logic          o_tbl_rd_req, o_tbl_wr_req;
  logic          i_tbl_rd_ack = 1'b0, i_tbl_wr_ack = 1'b0;
  logic [RB-1:0] o_tbl_rd_addr, o_tbl_wr_addr;
  logic [7:0]    i_tbl_rd_oif = '0;
  logic [31:0]   i_tbl_rd_nh = '0, i_tbl_rd_mask = '0, i_tbl_rd_net = '0;
  logic [31:0]   o_tbl_wr_oif, o_tbl_wr_nh, o_tbl_wr_mask, o_tbl_wr_net;

  ipv4_fib_table_ctrl #(.IPV4_FIB_LUT_ROW_BITS(RB), .TIMEOUT_CYCLES(TC)) dut (
    .Bus2IP_Clk(Bus2IP_Clk), .reset(reset), .Bus2IP_CS(Bus2IP_CS),
    .Bus2IP_RNW(Bus2IP_RNW), .Bus2IP_Addr(Bus2IP_Addr), .Bus2IP_Data(Bus2IP_Data),
    .IP2Bus_Data(IP2Bus_Data), .IP2Bus_RdAck(IP2Bus_RdAck), .IP2Bus_WrAck(IP2Bus_WrAck),
    .IP2Bus_Error(IP2Bus_Error), .o_tbl_rd_req(o_tbl_rd_req), .o_tbl_wr_req(o_tbl_wr_req),
    .i_tbl_rd_ack(i_tbl_rd_ack), .i_tbl_wr_ack(i_tbl_wr_ack),
    .o_tbl_rd_addr(o_tbl_rd_addr), .o_tbl_wr_addr(o_tbl_wr_addr),
    .i_tbl_rd_oif(i_tbl_rd_oif), .i_tbl_rd_nh(i_tbl_rd_nh),
    .i_tbl_rd_mask(i_tbl_rd_mask), .i_tbl_rd_net(i_tbl_rd_net),
    .o_tbl_wr_oif(o_tbl_wr_oif), .o_tbl_wr_nh(o_tbl_wr_nh),
    .o_tbl_wr_mask(o_tbl_wr_mask), .o_tbl_wr_net(o_tbl_wr_net)
  );

  always #5 Bus2IP_Clk = ~Bus2IP_Clk;

  int cyc = 0;
  always @(posedge Bus2IP_Clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: register contents and status as the bus should see them.
  logic [7:0]    m_oif;
  logic [31:0]   m_nh, m_mask, m_net;
  logic [RB-1:0] m_idx;
  bit            m_busy, m_done, m_tmo;
  int            m_tcnt;

  function automatic logic [31:0] m_read(input int a);
    case (a)
      0: return {24'b0, m_oif};
      1: return m_nh;
      2: return m_mask;
      3: return m_net;
      4: return 32'(m_idx);
      6: return {29'b0, m_tmo, m_done, m_busy};
      7: return 32'(m_tcnt);
      default: return 32'b0;
    endcase
  endfunction

  task automatic m_reset();
    m_oif = '0; m_nh = '0; m_mask = '0; m_net = '0; m_idx = '0;
    m_busy = 0; m_done = 0; m_tmo = 0; m_tcnt = 0;
  endtask

  task automatic m_write(input int a, input logic [31:0] d);
    case (a)
      0: m_oif = d[7:0];
      1: m_nh = d;
      2: m_mask = d;
      3: m_net = d;
      4: m_idx = d[RB-1:0];
      5: begin m_busy = 1; m_done = 0; m_tmo = 0; end
      default: ;
    endcase
  endtask

  // Table responder: ack t_dly cycles after a request (0 = never), with an
  // optional wrong-kind ack in the first WAIT cycle.
  int            t_dly = 1;
  bit            t_spur = 0;
  int            t_cnt = 0;
  bit            t_rd = 0;
  int            nreq = 0;
  int            req_cyc = 0;
  bit            req_was_rd = 0;
  logic [RB-1:0] req_addr;
  logic [31:0]   req_oif, req_nh, req_mask, req_net;

  initial begin
    forever begin
      @(posedge Bus2IP_Clk); #1;
      i_tbl_rd_ack = 1'b0;
      i_tbl_wr_ack = 1'b0;
      if (t_cnt > 0) begin
        t_cnt--;
        if (t_cnt == 0) begin
          if (t_rd) i_tbl_rd_ack = 1'b1;
          else      i_tbl_wr_ack = 1'b1;
        end else if (t_spur && t_cnt == t_dly - 1) begin
          if (t_rd) i_tbl_wr_ack = 1'b1;
          else      i_tbl_rd_ack = 1'b1;
        end
      end
      if (o_tbl_rd_req || o_tbl_wr_req) begin
        nreq       = nreq + int'(o_tbl_rd_req) + int'(o_tbl_wr_req);
        req_cyc    = cyc;
        req_was_rd = o_tbl_rd_req;
        req_addr   = o_tbl_rd_req ? o_tbl_rd_addr : o_tbl_wr_addr;
        req_oif    = o_tbl_wr_oif;
        req_nh     = o_tbl_wr_nh;
        req_mask   = o_tbl_wr_mask;
        req_net    = o_tbl_wr_net;
        t_rd       = o_tbl_rd_req;
        t_cnt      = t_dly;
      end
    end
  end

  int last_ack_cyc = 0;

  task automatic bus_write(input int a, input logic [31:0] d, output logic err);
    Bus2IP_CS = 1'b1; Bus2IP_RNW = 1'b0; Bus2IP_Addr = 3'(a); Bus2IP_Data = d;
    @(posedge Bus2IP_Clk); #1;
    chk("wr_ack", {31'b0, IP2Bus_WrAck}, 32'd1);
    err = IP2Bus_Error;
    last_ack_cyc = cyc;
    @(posedge Bus2IP_Clk); #1;
    chk("wr_ack_once", {30'b0, IP2Bus_WrAck, IP2Bus_Error}, 32'd0);
    Bus2IP_CS = 1'b0;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    Bus2IP_CS = 1'b1; Bus2IP_RNW = 1'b1; Bus2IP_Addr = 3'(a);
    @(posedge Bus2IP_Clk); #1;
    chk("rd_ack", {30'b0, IP2Bus_RdAck, IP2Bus_Error}, 32'd2);
    d = IP2Bus_Data;
    @(posedge Bus2IP_Clk); #1;
    chk("rd_ack_once", {31'b0, IP2Bus_RdAck}, 32'd0);
    Bus2IP_CS = 1'b0;
  endtask

  task automatic wr_exp(input int a, input logic [31:0] d, input bit exp_err);
    logic e;
    bus_write(a, d, e);
    chk($sformatf("wr_err a%0d", a), {31'b0, e}, {31'b0, exp_err});
    if (!exp_err) m_write(a, d);
  endtask

  task automatic check_all();
    logic [31:0] v;
    for (int a = 0; a < 8; a++) begin
      bus_read(a, v);
      chk($sformatf("reg%0d", a), v, m_read(a));
    end
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    st = 32'd1;
    for (int i = 0; i < 40 && st[0]; i++) bus_read(6, st);
    chk("busy_clears", {31'b0, st[0]}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge Bus2IP_Clk); #1;
    chk("rst_outs", {26'b0, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error,
                     o_tbl_rd_req, o_tbl_wr_req, |IP2Bus_Data}, 32'd0);
    @(posedge Bus2IP_Clk); #1;
    reset = 1'b0;
    m_reset();
  endtask

  // Full command: issue, wait for completion, then check request and model.
  task automatic do_op(input bit rd, input int d, input bit spur);
    logic [31:0] cmd;
    int n0, ack_c;
    t_dly = d; t_spur = spur;
    n0 = nreq;
    cmd = $urandom;
    cmd[1:0] = rd ? 2'b10 : 2'b01;
    wr_exp(5, cmd, 0);
    ack_c = last_ack_cyc;
    wait_idle();
    chk("nreq", 32'(nreq - n0), 32'd1);
    chk("req_kind", {31'b0, req_was_rd}, {31'b0, rd});
    chk("req_latency", 32'(req_cyc - ack_c), 32'd1);
    chk("req_addr", 32'(req_addr), 32'(m_idx));
    if (!rd) begin
      chk("wr_oif", req_oif, {24'b0, m_oif});
      chk("wr_nh", req_nh, m_nh);
      chk("wr_mask", req_mask, m_mask);
      chk("wr_net", req_net, m_net);
    end
    m_busy = 0;
    if (d >= 1 && d <= TC) begin
      m_done = 1;
      if (rd) begin
        m_oif = i_tbl_rd_oif; m_nh = i_tbl_rd_nh;
        m_mask = i_tbl_rd_mask; m_net = i_tbl_rd_net;
      end
    end else begin
      m_tmo = 1;
      if (m_tcnt < 16'hFFFF) m_tcnt++;
    end
  endtask

  initial begin
    logic [31:0] v;
    int n0;
    m_reset();
    do_reset();
    check_all();

    // Table write of one route.
    wr_exp(1, 32'h0A000001, 0);
    wr_exp(2, 32'hFFFFFF00, 0);
    wr_exp(3, 32'h0A000000, 0);
    wr_exp(0, 32'h00000055, 0);
    wr_exp(4, 32'd3, 0);
    do_op(0, 1, 0);
    check_all();

    // Table read of row 7.
    wr_exp(4, 32'd7, 0);
    i_tbl_rd_oif = 8'h04; i_tbl_rd_nh = 32'hC0A80101;
    i_tbl_rd_mask = $urandom; i_tbl_rd_net = $urandom;
    do_op(1, 1, 0);
    check_all();

    // Timeout with writes attempted while busy.
    t_dly = 0; t_spur = 0;
    n0 = nreq;
    wr_exp(5, 32'd1, 0);
    wr_exp(1, 32'h12345678, 1);
    wr_exp(5, 32'd1, 1);
    wr_exp(4, 32'd9, 1);
    bus_read(1, v);
    chk("rd_while_busy", v, m_nh);
    wait_idle();
    chk("tmo_nreq", 32'(nreq - n0), 32'd1);
    m_busy = 0; m_tmo = 1; m_tcnt++;
    check_all();

    // Illegal commands and read-only writes while idle.
    n0 = nreq;
    wr_exp(5, 32'd3, 1);
    wr_exp(5, 32'd0, 1);
    wr_exp(6, 32'hFFFFFFFF, 1);
    wr_exp(7, 32'h0000FFFF, 1);
    repeat (6) @(posedge Bus2IP_Clk);
    #1;
    chk("bad_cmd_nreq", 32'(nreq - n0), 32'd0);
    check_all();

    // Ack in the last WAIT cycle completes; one later times out.
    i_tbl_rd_oif = $urandom; i_tbl_rd_nh = $urandom;
    do_op(1, TC, 0);
    check_all();
    do_op(0, TC + 1, 0);
    check_all();

    // Wrong-kind ack during a read is ignored.
    i_tbl_rd_net = $urandom;
    do_op(1, 3, 1);
    check_all();

    // Reset in WAIT of a read, then a late ack.
    i_tbl_rd_nh = 32'hDEADBEEF;
    t_dly = 8; t_spur = 0;
    wr_exp(5, 32'd2, 0);
    repeat (3) @(posedge Bus2IP_Clk);
    #1;
    do_reset();
    repeat (10) @(posedge Bus2IP_Clk);
    #1;
    check_all();

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      int n, r, d, sel;
      bit rd, spur;
      logic [31:0] bad;
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) wr_exp($urandom_range(0, 4), $urandom, 0);
      if ($urandom_range(0, 3) == 0) begin
        sel = $urandom_range(0, 3);
        bad = $urandom;
        if (sel == 0) begin bad[1:0] = 2'b00; wr_exp(5, bad, 1); end
        else if (sel == 1) begin bad[1:0] = 2'b11; wr_exp(5, bad, 1); end
        else wr_exp(sel + 4, bad, 1);
      end
      rd = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      d = (r == 0) ? 0 : (r == 1) ? $urandom_range(TC - 1, TC + 2) : $urandom_range(1, 4);
      spur = (d >= 2) && ($urandom_range(0, 2) == 0);
      i_tbl_rd_oif = $urandom; i_tbl_rd_nh = $urandom;
      i_tbl_rd_mask = $urandom; i_tbl_rd_net = $urandom;
      do_op(rd, d, spur);
      check_all();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end
endmodule
